// File: rtl/cond_logic_pkg.sv
// rtl/cond_logic_pkg.sv - shared condition codes and flag bit positions
package cond_logic_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_cond_check.sv
// rtl/cond_logic_cond_check.sv - combinational ARM condition evaluator
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    n       = flags[FLAG_N];
    z       = flags[FLAG_Z];
    c       = flags[FLAG_C];
    v       = flags[FLAG_V];
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ~(n ^ v);
      COND_LT: cond_ex = n ^ v;
      COND_GT: cond_ex = ~z & ~(n ^ v);
      COND_LE: cond_ex = z | (n ^ v);
      COND_AL: cond_ex = 1'b1;
      // reserved encoding in ARMv3, treated as never
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register and condition-gated write enables
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Stall,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       commit;

  assign Flags = {nz_q, cv_q};

  // evaluated against stored flags only, so no path back through the ALU
  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (Flags),
    .cond_ex (CondEx)
  );

  always_comb begin
    commit   = CondEx & ~Stall;
    nz_d     = nz_q;
    cv_d     = cv_q;
    if (commit && FlagW[FLAGW_NZ]) nz_d = ALUFlags[FLAG_N:FLAG_Z];
    if (commit && FlagW[FLAGW_CV]) cv_d = ALUFlags[FLAG_C:FLAG_V];
    PCSrc    = PCS & commit;
    RegWrite = RegW & commit & ~NoWrite;
    MemWrite = MemW & commit;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      nz_q <= FLAG_RESET[3:2];
      cv_q <= FLAG_RESET[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - randomized self-checking bench for cond_logic
module tb_cond_logic;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       Stall;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] flags_m;

  cond_logic #(.FLAG_RESET(4'b0000)) dut (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // condition pairs share a base predicate; the odd code inverts it
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  // called just after a falling edge; checks outputs, then crosses one rising edge
  task automatic apply(input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic nowr, input logic stl);
    logic ce;
    Cond = cc; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = regw;
    MemW = memw; NoWrite = nowr; Stall = stl;
    #1;
    ce = ref_cond(cc, flags_m);
    check("flags", Flags, flags_m);
    check("condex", {3'b0, CondEx}, {3'b0, ce});
    check("pcsrc", {3'b0, PCSrc}, {3'b0, pcs & ce & !stl});
    check("regwrite", {3'b0, RegWrite}, {3'b0, regw & ce & !nowr & !stl});
    check("memwrite", {3'b0, MemWrite}, {3'b0, memw & ce & !stl});
    @(posedge CLK);
    if (ce && !stl) begin
      if (fw[1]) flags_m[3:2] = alu[3:2];
      if (fw[0]) flags_m[1:0] = alu[1:0];
    end
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; Stall = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    flags_m = 4'b0000;
    repeat (2) @(negedge CLK);
    check("reset_flags", Flags, 4'b0000);
    check("reset_condex_al", {3'b0, CondEx}, 4'd1);
    RESET = 1'b0;

    // asynchronous reset with flags at 1111, no clock edge involved
    apply(4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0);
    check("preload_1111", Flags, 4'b1111);
    Cond = 4'h0; RegW = 1; FlagW = 0;
    #2 RESET = 1'b1;
    #1;
    flags_m = 4'b0000;
    check("async_clear", Flags, 4'b0000);
    check("async_eq", {3'b0, CondEx}, 4'd0);
    check("async_regw", {3'b0, RegWrite}, 4'd0);
    Cond = 4'h1; #1;
    check("async_ne", {3'b0, CondEx}, 4'd1);
    check("async_ne_regw", {3'b0, RegWrite}, 4'd1);
    RESET = 1'b0;
    @(negedge CLK);

    // CMP: flags written, register write suppressed
    apply(4'hE, 4'b0110, 2'b11, 0, 1, 0, 1, 0);
    check("cmp_flags", Flags, 4'b0110);
    Cond = 4'h0; #1;
    check("cmp_eq", {3'b0, CondEx}, 4'd1);
    @(negedge CLK);

    // NZ-only update keeps C,V
    apply(4'hE, 4'b1001, 2'b10, 0, 0, 0, 0, 0);
    check("partial_flags", Flags, 4'b1010);

    // failing condition blocks everything
    apply(4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    apply(4'h0, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    check("fail_noupdate", Flags, 4'b0000);

    // signed conditions
    apply(4'hE, 4'b1000, 2'b11, 0, 0, 0, 0, 0);
    Cond = 4'hB; #1; check("lt_1000", {3'b0, CondEx}, 4'd1);
    Cond = 4'hA; #1; check("ge_1000", {3'b0, CondEx}, 4'd0);
    Cond = 4'hC; #1; check("gt_1000", {3'b0, CondEx}, 4'd0);
    Cond = 4'hD; #1; check("le_1000", {3'b0, CondEx}, 4'd1);
    @(negedge CLK);
    apply(4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
    Cond = 4'hA; #1; check("ge_1001", {3'b0, CondEx}, 4'd1);
    Cond = 4'hC; #1; check("gt_1001", {3'b0, CondEx}, 4'd1);
    @(negedge CLK);

    // full sweep of conditions over every flag value
    for (int f = 0; f < 16; f++) begin
      apply(4'hE, f[3:0], 2'b11, 0, 0, 0, 0, 0);
      FlagW = 2'b00;
      for (int cc = 0; cc < 16; cc++) begin
        Cond = cc[3:0]; #1;
        check("sweep", {3'b0, CondEx}, {3'b0, ref_cond(cc[3:0], f[3:0])});
      end
      @(negedge CLK);
    end

    // stall holds flags and kills enables
    apply(4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 1);
      check("stall_hold", Flags, 4'b0000);
    end
    apply(4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 0);
    check("stall_release", Flags, 4'b1111);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end
    #1 check("final_flags", Flags, flags_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
